mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//   M-stage data-memory access controller. Takes one load/store per instruction, checks alignment,
//   builds byte enables and lane-replicated store data, and runs a req/ack bus handshake. Stalls
//   the pipeline until the bus acks, then registers raw word, addr[1:0] and load op into W stage
//   for the downstream load-extension stage.
// PARAMETERS
//   TIMEOUT  255  max WAIT cycles before bus error; 0 = no timeout
// PORTS
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous reset, active-low
//   m_valid    in   1   M-stage holds a valid instruction
//   m_addr     in   32  effective byte address
//   m_wdata    in   32  store source register (low bits used for sb/sh)
//   m_ld_op    in   3   000 none, 111 lw, 001 lbu, 010 lb, 011 lhu, 100 lh
//   m_st_op    in   2   00 none, 01 sb, 10 sh, 11 sw (never nonzero together with m_ld_op)
//   flush      in   1   exception/eret kill of M-stage instruction
//   bus_req    out  1   registered request, held until bus_ack
//   bus_we     out  1   1 = write
//   bus_addr   out  32  word address {m_addr[31:2],2'b00}
//   bus_be     out  4   byte enables (write only; 4'b0000 for reads)
//   bus_wdata  out  32  lane-replicated store data
//   bus_ack    in   1   one-cycle completion pulse; bus_rdata valid in same cycle
//   bus_rdata  in   32  read word
//   stall      out  1   freeze F/D/E/M stages
//   exc_adel   out  1   comb: misaligned load (lw addr[1:0]!=0; lh/lhu addr[0]!=0)
//   exc_ades   out  1   comb: misaligned store (sw/sh same rules)
//   exc_buserr out  1   one-cycle pulse on timeout
//   w_rdata    out  32  registered raw word to W stage
//   w_ad       out  2   registered m_addr[1:0]
//   w_ld_op    out  3   registered load op; 000 = no load
// BEHAVIOUR
//   - Reset: state IDLE, bus_req/bus_we 0, bus_addr/bus_wdata 0, bus_be 0, timer 0, flush_pend 0,
//     w_rdata 0, w_ad 0, w_ld_op 000. Reset mid-transaction: async return to IDLE, request dropped.
//   - start = m_valid & (ld|st) & ~exc_adel & ~exc_ades & ~flush.
//   - FSM IDLE -> WAIT: on start; latch bus_* outputs; bus_req=1 next cycle. stall=start in IDLE.
//   - WAIT: stall=1; bus_* held stable. On bus_ack: latch bus_rdata into rdata_q; -> DONE.
//     Timer counts WAIT cycles; when timer==TIMEOUT (TIMEOUT!=0) with no ack: drop req,
//     pulse exc_buserr, -> DONE. An ack in the same cycle as timeout wins (no error).
//   - DONE: stall=0, no new issue (one-cycle bubble; prevents re-issue of same instruction); -> IDLE.
//   - Min latency, ack in first WAIT cycle: IDLE(stall), WAIT(stall), DONE(release) = 3 cycles.
//   - Flush in IDLE suppresses start. Flush in WAIT does not abort the bus: set flush_pend,
//     complete handshake, discard data (w_ld_op=000). flush_pend cleared in DONE.
//   - W regs update every cycle with stall==0: w_ld_op <= (valid load, no flush/flush_pend/exc)?
//     m_ld_op:000; w_ad <= m_addr[1:0]; w_rdata <= rdata_q.
//   - Store formatting: sb be=4'b0001<<ad, wdata={4{b}}; sh be=ad[1]?1100:0011, wdata={2{h}};
//     sw be=1111, wdata=m_wdata. Reads: be=0000, we=0.
//   - Timer 8 bits wide (TIMEOUT<=255), saturates, cleared on entry to WAIT.
// STRUCTURE
//   - Shared package: LD_* (3-bit) and ST_* (2-bit) op encodings, FSM state encodings
//     (IDLE/WAIT/DONE); also imported by the load-extension stage.
//   - One sub-module: mem_store_align (comb): addr[1:0], st_op, ld_op, wdata -> be, wdata_rep,
//     exc_adel, exc_ades.
// TESTING
//   - sw addr 0x1004 data 0xDEADBEEF, ack 1st WAIT cycle -> be=1111, stall 2 cycles, released 3rd.
//   - sb addr 0x1003 data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5; sh 0x1002 0x1234 -> be=1100, 0x12341234.
//   - lb addr 0x2001, ack after 4 WAIT cycles rdata 0x11228033 -> w_rdata=0x11228033, w_ad=01, w_ld_op=010.
//   - lw addr 0x2002 -> exc_adel=1, bus_req never asserts, stall=0, w_ld_op=000; sh 0x2001 -> exc_ades=1.
//   - TIMEOUT=4, no ack -> exc_buserr pulses after 4 WAIT cycles, req drops; ack on timeout cycle -> no error.
//   - flush 2nd WAIT cycle, ack later -> transaction completes, w_ld_op=000; rst_n low in WAIT -> bus_req=0 at once.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the M-stage memory access controller and the W-stage load-extension logic.
package mem_access_ctrl_pkg;

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LBU  = 3'b001;
    localparam logic [2:0] LD_LB   = 3'b010;
    localparam logic [2:0] LD_LHU  = 3'b011;
    localparam logic [2:0] LD_LH   = 3'b100;
    localparam logic [2:0] LD_LW   = 3'b111;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SW   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } mac_state_t;

    function automatic logic is_half_ld(input logic [2:0] op);
        return (op == LD_LH) || (op == LD_LHU);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the access controller (master) and the memory system (slave).
interface mem_access_ctrl_if;
    // bus_req rises with the other bus_* fields already stable and holds them unchanged
    // until the slave returns a one-cycle bus_ack; bus_rdata is valid in the ack cycle only.
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_store_align.sv
// Byte-lane formatting for stores and alignment checks for loads/stores.
module mem_store_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  i_ad,
    input  logic [1:0]  i_st_op,
    input  logic [2:0]  i_ld_op,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_rep,
    output logic        o_adel,
    output logic        o_ades
);

    always_comb begin
        o_be        = 4'b0000;
        o_wdata_rep = 32'h0;
        case (i_st_op)
            ST_SB: begin
                o_be        = 4'b0001 << i_ad;
                o_wdata_rep = {4{i_wdata[7:0]}};
            end
            ST_SH: begin
                o_be        = i_ad[1] ? 4'b1100 : 4'b0011;
                o_wdata_rep = {2{i_wdata[15:0]}};
            end
            ST_SW: begin
                o_be        = 4'b1111;
                o_wdata_rep = i_wdata;
            end
            default: ;
        endcase
    end

    assign o_adel = ((i_ld_op == LD_LW) && (i_ad != 2'b00)) || (is_half_ld(i_ld_op) && i_ad[0]);
    assign o_ades = ((i_st_op == ST_SW) && (i_ad != 2'b00)) || ((i_st_op == ST_SH) && i_ad[0]);

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage data-memory access controller: issues one bus transaction per load/store,
// stalls the pipeline until it completes, and hands the raw read word to the W stage.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_valid,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [2:0]  m_ld_op,
    input  logic [1:0]  m_st_op,
    input  logic        flush,
    mem_access_ctrl_if.master bus,
    output logic        stall,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_buserr,
    output logic [31:0] w_rdata,
    output logic [1:0]  w_ad,
    output logic [2:0]  w_ld_op,
    output mac_state_t  dbg_state
);

    localparam logic [7:0] TMO    = TIMEOUT[7:0];
    localparam bit         TMO_EN = (TIMEOUT != 0);

    mac_state_t  r_state;
    logic [7:0]  r_timer;
    logic        r_flush_pend;
    logic [31:0] r_rdata_q;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_buserr;
    logic [31:0] r_w_rdata;
    logic [1:0]  r_w_ad;
    logic [2:0]  r_w_ld_op;

    logic [3:0]  w_sa_be;
    logic [31:0] w_sa_wdata;
    logic        w_sa_adel;
    logic        w_sa_ades;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_start;
    logic        w_timeout;

    mem_store_align u_store_align (
        .i_ad        (m_addr[1:0]),
        .i_st_op     (m_st_op),
        .i_ld_op     (m_ld_op),
        .i_wdata     (m_wdata),
        .o_be        (w_sa_be),
        .o_wdata_rep (w_sa_wdata),
        .o_adel      (w_sa_adel),
        .o_ades      (w_sa_ades)
    );

    assign w_is_ld   = (m_ld_op != LD_NONE);
    assign w_is_st   = (m_st_op != ST_NONE);
    assign exc_adel  = m_valid & w_sa_adel;
    assign exc_ades  = m_valid & w_sa_ades;
    assign w_start   = m_valid & (w_is_ld | w_is_st) & ~exc_adel & ~exc_ades & ~flush;
    assign w_timeout = TMO_EN && (r_timer == TMO);
    assign stall     = ((r_state == S_IDLE) & w_start) | (r_state == S_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_timer      <= 8'd0;
            r_flush_pend <= 1'b0;
            r_rdata_q    <= 32'h0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'h0;
            r_be         <= 4'b0000;
            r_wdata      <= 32'h0;
            r_buserr     <= 1'b0;
        end else begin
            r_buserr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_req   <= 1'b1;
                        r_we    <= w_is_st;
                        r_addr  <= {m_addr[31:2], 2'b00};
                        r_be    <= w_sa_be;
                        r_wdata <= w_sa_wdata;
                        r_timer <= 8'd0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A flush cannot retract a request already on the bus; remember it instead.
                    if (flush) r_flush_pend <= 1'b1;
                    if (r_timer != 8'hFF) r_timer <= r_timer + 8'd1;
                    if (bus.bus_ack) begin
                        r_rdata_q <= bus.bus_rdata;
                        r_req     <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (w_timeout) begin
                        r_req    <= 1'b0;
                        r_buserr <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_flush_pend <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The M-stage instruction is still present during DONE, so that is when its load reaches W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_rdata <= 32'h0;
            r_w_ad    <= 2'b00;
            r_w_ld_op <= LD_NONE;
        end else if (!stall) begin
            r_w_rdata <= r_rdata_q;
            r_w_ad    <= m_addr[1:0];
            r_w_ld_op <= (m_valid & w_is_ld & ~flush & ~r_flush_pend & ~exc_adel & ~r_buserr)
                         ? m_ld_op : LD_NONE;
        end
    end

    assign bus.bus_req   = r_req;
    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_be    = r_be;
    assign bus.bus_wdata = r_wdata;
    assign exc_buserr    = r_buserr;
    assign w_rdata       = r_w_rdata;
    assign w_ad          = r_w_ad;
    assign w_ld_op       = r_w_ld_op;
    assign dbg_state     = r_state;

endmodule
